nnrv_wb_arb: RTL and testbench

- Shares the single register-file write port between two writeback requesters: execute (EX) results and load (LD) returns.
- Each requester gets a one-entry holding slot with a valid/ready handshake; the arbiter grants one slot per cycle and drives a registered write request into the register-file write port.
- Also reports pending-write hazards for the two read addresses, so the issue stage can stall.

---
 rtl/nnrv_pkg.sv | 13 +
 rtl/nnrv_wb_slot.sv | 32 +++
 rtl/nnrv_wb_arb.sv | 123 ++++++++++++
 tb/tb_nnrv_wb_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nnrv_pkg.sv
// Shared constants for the nnrv writeback path: register-file geometry and
// requester identifiers used by the writeback arbiter.
package nnrv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_AW  = $clog2(REG_NUM);

    // Requester IDs for the round-robin pointer and the age flag
    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_LD = 1'b1;

endpackage

// File: rtl/nnrv_wb_slot.sv
// One-entry writeback holding slot. Writes to x0 are accepted but dropped,
// so they never occupy the slot.
import nnrv_pkg::*;

module nnrv_wb_slot (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              load,
    input  logic              clear,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_data,
    output logic              valid,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   data
);

    // Load wins over clear so a slot can be granted and refilled on one edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid <= 1'b0;
            rd    <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= (in_rd != '0);
            rd    <= in_rd;
            data  <= in_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nnrv_wb_arb.sv
// Writeback arbiter: shares the register-file write port between the EX and
// LD requesters and reports pending writes for the issue-stage read ports.
import nnrv_pkg::*;

module nnrv_wb_arb (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [XLEN-1:0]   i_ex_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [REG_AW-1:0] i_ld_rd,
    input  logic [XLEN-1:0]   i_ld_data,
    output logic              o_w_en,
    output logic [REG_AW-1:0] o_w,
    output logic [XLEN-1:0]   o_w_reg,
    input  logic [REG_AW-1:0] i_r1,
    input  logic [REG_AW-1:0] i_r2,
    output logic              o_r1_pend,
    output logic              o_r2_pend,
    output logic              o_idle
);

    logic              ex_v, ld_v;
    logic [REG_AW-1:0] ex_rd, ld_rd;
    logic [XLEN-1:0]   ex_data, ld_data;
    logic              gnt_ex, gnt_ld, pick;
    logic              acc_ex, acc_ld;
    logic              rr_q, age_q;

    assign acc_ex = i_ex_valid && o_ex_ready;
    assign acc_ld = i_ld_valid && o_ld_ready;

    nnrv_wb_slot u_ex_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (acc_ex),
        .clear   (gnt_ex),
        .in_rd   (i_ex_rd),
        .in_data (i_ex_data),
        .valid   (ex_v),
        .rd      (ex_rd),
        .data    (ex_data)
    );

    nnrv_wb_slot u_ld_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (acc_ld),
        .clear   (gnt_ld),
        .in_rd   (i_ld_rd),
        .in_data (i_ld_data),
        .valid   (ld_v),
        .rd      (ld_rd),
        .data    (ld_data)
    );

    // Same destination must retire in order (age); otherwise alternate
    always_comb begin
        gnt_ex = 1'b0;
        gnt_ld = 1'b0;
        pick   = REQ_EX;
        if (ex_v && ld_v) begin
            pick   = (ex_rd == ld_rd) ? age_q : rr_q;
            gnt_ex = (pick == REQ_EX);
            gnt_ld = (pick == REQ_LD);
        end else begin
            gnt_ex = ex_v;
            gnt_ld = ld_v;
        end
    end

    assign o_ex_ready = !ex_v || gnt_ex;
    assign o_ld_ready = !ld_v || gnt_ld;

    // rr_q names the preferred requester; age_q names the older slot entry
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_q  <= REQ_EX;
            age_q <= REQ_EX;
        end else begin
            if (gnt_ex)
                rr_q <= REQ_LD;
            else if (gnt_ld)
                rr_q <= REQ_EX;
            if (acc_ex)
                age_q <= REQ_LD;
            else if (acc_ld)
                age_q <= REQ_EX;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_w_en  <= 1'b0;
            o_w     <= '0;
            o_w_reg <= '0;
        end else if (gnt_ex) begin
            o_w_en  <= 1'b1;
            o_w     <= ex_rd;
            o_w_reg <= ex_data;
        end else if (gnt_ld) begin
            o_w_en  <= 1'b1;
            o_w     <= ld_rd;
            o_w_reg <= ld_data;
        end else begin
            o_w_en  <= 1'b0;
        end
    end

    function automatic logic pend_of(input logic [REG_AW-1:0] r);
        return (r != '0) && ((ex_v && ex_rd == r) ||
                             (ld_v && ld_rd == r) ||
                             (o_w_en && o_w == r));
    endfunction

    assign o_r1_pend = pend_of(i_r1);
    assign o_r2_pend = pend_of(i_r2);
    assign o_idle    = !ex_v && !ld_v && !o_w_en;

endmodule

// File: tb/tb_nnrv_wb_arb.sv
// Directed bench for the writeback arbiter: latency, arbitration order,
// streaming throughput, x0 discard, pending hazards and reset abort.
module tb_nnrv_wb_arb;
    import nnrv_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_ex_valid, i_ld_valid;
    logic              o_ex_ready, o_ld_ready;
    logic [REG_AW-1:0] i_ex_rd, i_ld_rd, i_r1, i_r2;
    logic [XLEN-1:0]   i_ex_data, i_ld_data;
    logic              o_w_en, o_r1_pend, o_r2_pend, o_idle;
    logic [REG_AW-1:0] o_w;
    logic [XLEN-1:0]   o_w_reg;

    int checks = 0;
    int errors = 0;
    int w4_cnt = 0;

    nnrv_wb_arb dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ex_valid (i_ex_valid),
        .o_ex_ready (o_ex_ready),
        .i_ex_rd    (i_ex_rd),
        .i_ex_data  (i_ex_data),
        .i_ld_valid (i_ld_valid),
        .o_ld_ready (o_ld_ready),
        .i_ld_rd    (i_ld_rd),
        .i_ld_data  (i_ld_data),
        .o_w_en     (o_w_en),
        .o_w        (o_w),
        .o_w_reg    (o_w_reg),
        .i_r1       (i_r1),
        .i_r2       (i_r2),
        .o_r1_pend  (o_r1_pend),
        .o_r2_pend  (o_r2_pend),
        .o_idle     (o_idle)
    );

    always #5 i_clk = ~i_clk;

    // Count register-file writes to x4 as seen by the register file
    always @(posedge i_clk) if (o_w_en && o_w == 5'd4) w4_cnt <= w4_cnt + 1;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_ex_valid = 1'b0; i_ex_rd = '0; i_ex_data = '0;
        i_ld_valid = 1'b0; i_ld_rd = '0; i_ld_data = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        i_rst = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        i_r1 = 5'd3; i_r2 = 5'd7;
        do_reset();
        checks++; if (o_w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got=%0b exp=0", o_w_en); end
        checks++; if (o_w !== 5'd0) begin errors++; $display("FAIL reset_w got=%0d exp=0", o_w); end
        checks++; if (o_w_reg !== 32'h0) begin errors++; $display("FAIL reset_w_reg got=%0h exp=0", o_w_reg); end
        checks++; if ({o_ex_ready, o_ld_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b exp=11", {o_ex_ready, o_ld_ready}); end
        checks++; if ({o_r1_pend, o_r2_pend} !== 2'b00) begin errors++; $display("FAIL reset_pend got=%b exp=00", {o_r1_pend, o_r2_pend}); end
        checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b exp=1", o_idle); end
    endtask

    task automatic test_single;
        i_ex_valid = 1'b1; i_ex_rd = 5'd3; i_ex_data = 32'h11;
        checks++; if (o_ex_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%0b exp=1", o_ex_ready); end
        tick();
        clear_inputs();
        checks++; if (o_w_en !== 1'b0 || o_idle !== 1'b0) begin errors++; $display("FAIL single_e0 w_en=%0b idle=%0b exp w_en=0 idle=0", o_w_en, o_idle); end
        tick();
        checks++; if (o_w_en !== 1'b1 || o_w !== 5'd3 || o_w_reg !== 32'h11) begin errors++; $display("FAIL single_write w_en=%0b w=%0d data=%0h exp 1/3/11", o_w_en, o_w, o_w_reg); end
        tick();
        checks++; if (o_w_en !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL single_idle w_en=%0b idle=%0b exp 0/1", o_w_en, o_idle); end
        checks++; if (o_w !== 5'd3 || o_w_reg !== 32'h11) begin errors++; $display("FAIL single_hold w=%0d data=%0h exp 3/11", o_w, o_w_reg); end
    endtask

    task automatic test_dual;
        do_reset();
        i_ex_valid = 1'b1; i_ex_rd = 5'd5; i_ex_data = 32'h55;
        i_ld_valid = 1'b1; i_ld_rd = 5'd6; i_ld_data = 32'h66;
        tick();
        clear_inputs();
        checks++; if (o_w_en !== 1'b0) begin errors++; $display("FAIL dual_e0 w_en=%0b exp=0", o_w_en); end
        tick();
        checks++; if (o_w_en !== 1'b1 || o_w !== 5'd5 || o_w_reg !== 32'h55) begin errors++; $display("FAIL dual_first w_en=%0b w=%0d data=%0h exp 1/5/55", o_w_en, o_w, o_w_reg); end
        tick();
        checks++; if (o_w_en !== 1'b1 || o_w !== 5'd6 || o_w_reg !== 32'h66) begin errors++; $display("FAIL dual_second w_en=%0b w=%0d data=%0h exp 1/6/66", o_w_en, o_w, o_w_reg); end
        tick();
        checks++; if (o_w_en !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL dual_done w_en=%0b idle=%0b exp 0/1", o_w_en, o_idle); end
    endtask

    task automatic test_same_rd;
        do_reset();
        i_ex_valid = 1'b1; i_ex_rd = 5'd7; i_ex_data = 32'hAA;
        i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'hBB;
        tick();
        clear_inputs();
        tick();
        checks++; if (o_w_en !== 1'b1 || o_w !== 5'd7 || o_w_reg !== 32'hBB) begin errors++; $display("FAIL same_rd_first w_en=%0b w=%0d data=%0h exp 1/7/bb", o_w_en, o_w, o_w_reg); end
        tick();
        checks++; if (o_w_en !== 1'b1 || o_w !== 5'd7 || o_w_reg !== 32'hAA) begin errors++; $display("FAIL same_rd_last w_en=%0b w=%0d data=%0h exp 1/7/aa", o_w_en, o_w, o_w_reg); end
        tick();
        checks++; if (o_w_en !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL same_rd_done w_en=%0b idle=%0b exp 0/1", o_w_en, o_idle); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_ld_valid = 1'b1; i_ld_rd = REG_AW'(9 + i); i_ld_data = XLEN'(32'h100 + i);
            checks++; if (o_ld_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, o_ld_ready); end
            tick();
            if (i > 0) begin
                checks++;
                if (o_w_en !== 1'b1 || o_w !== REG_AW'(8 + i) || o_w_reg !== XLEN'(32'hFF + i)) begin
                    errors++; $display("FAIL b2b_write[%0d] w_en=%0b w=%0d data=%0h exp 1/%0d/%0h", i, o_w_en, o_w, o_w_reg, 8 + i, 32'hFF + i);
                end
            end
        end
        clear_inputs();
        tick();
        checks++; if (o_w_en !== 1'b1 || o_w !== 5'd12 || o_w_reg !== 32'h103) begin errors++; $display("FAIL b2b_last w_en=%0b w=%0d data=%0h exp 1/12/103", o_w_en, o_w, o_w_reg); end
        tick();
        checks++; if (o_w_en !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL b2b_done w_en=%0b idle=%0b exp 0/1", o_w_en, o_idle); end
    endtask

    task automatic test_x0;
        do_reset();
        i_r1 = 5'd0;
        i_ex_valid = 1'b1; i_ex_rd = 5'd0; i_ex_data = 32'hFF;
        checks++; if (o_ex_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0b exp=1", o_ex_ready); end
        tick();
        clear_inputs();
        checks++; if (o_idle !== 1'b1 || o_r1_pend !== 1'b0) begin errors++; $display("FAIL x0_slot idle=%0b pend=%0b exp 1/0", o_idle, o_r1_pend); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_w_en !== 1'b0) begin errors++; $display("FAIL x0_no_write[%0d] w_en=%0b exp=0", i, o_w_en); end
        end
    endtask

    task automatic test_pend;
        int cnt0;
        do_reset();
        i_r1 = 5'd4; i_r2 = 5'd5;
        i_ex_valid = 1'b1; i_ex_rd = 5'd4; i_ex_data = 32'h44;
        checks++; if (o_r1_pend !== 1'b0) begin errors++; $display("FAIL pend_before got=%0b exp=0", o_r1_pend); end
        tick();
        clear_inputs();
        checks++; if (o_r1_pend !== 1'b1 || o_r2_pend !== 1'b0) begin errors++; $display("FAIL pend_slot r1=%0b r2=%0b exp 1/0", o_r1_pend, o_r2_pend); end
        tick();
        checks++; if (o_r1_pend !== 1'b1 || o_w_en !== 1'b1) begin errors++; $display("FAIL pend_write r1=%0b w_en=%0b exp 1/1", o_r1_pend, o_w_en); end
        tick();
        checks++; if (o_r1_pend !== 1'b0) begin errors++; $display("FAIL pend_after got=%0b exp=0", o_r1_pend); end
        // Reset while a write to x4 is still sitting in the slot
        cnt0 = w4_cnt;
        i_ex_valid = 1'b1; i_ex_rd = 5'd4; i_ex_data = 32'h99;
        tick();
        clear_inputs();
        checks++; if (o_r1_pend !== 1'b1) begin errors++; $display("FAIL abort_pend_pre got=%0b exp=1", o_r1_pend); end
        #2 i_rst = 1'b0;
        #1;
        checks++; if (o_w_en !== 1'b0 || o_r1_pend !== 1'b0 || o_idle !== 1'b1) begin errors++; $display("FAIL abort_async w_en=%0b pend=%0b idle=%0b exp 0/0/1", o_w_en, o_r1_pend, o_idle); end
        tick();
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_w_en !== 1'b0 || o_r1_pend !== 1'b0) begin errors++; $display("FAIL abort_quiet[%0d] w_en=%0b pend=%0b exp 0/0", i, o_w_en, o_r1_pend); end
        end
        checks++; if (w4_cnt !== cnt0) begin errors++; $display("FAIL abort_x4_writes got=%0d exp=%0d", w4_cnt, cnt0); end
    endtask

    initial begin
        i_rst = 1'b0;
        i_r1 = '0; i_r2 = '0;
        clear_inputs();
        test_reset();
        test_single();
        test_dual();
        test_same_rd();
        test_back_to_back();
        test_x0();
        test_pend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
